// File: rtl/mem_ctrl_pkg.sv
// Shared constants and types for the memory-access sequencer: address-mux select
// codes, FSM state and grant encodings, and the grant/cause -> select mapping.
package mem_ctrl_pkg;

    localparam logic [2:0] SEL_PC     = 3'b000;
    localparam logic [2:0] SEL_ALUOUT = 3'b011;
    localparam logic [2:0] SEL_V253   = 3'b100;
    localparam logic [2:0] SEL_V254   = 3'b101;
    localparam logic [2:0] SEL_V255   = 3'b110;

    typedef enum logic [1:0] {IDLE, ADDR, WAIT, DONE} state_t;

    typedef enum logic [1:0] {G_FETCH, G_DATA, G_EXC} grant_t;

    // Causes 00 and 11 both fall through to the last vector.
    function automatic logic [2:0] cause_to_sel(input logic [1:0] cause);
        case (cause)
            2'b01:   return SEL_V253;
            2'b10:   return SEL_V254;
            default: return SEL_V255;
        endcase
    endfunction

    function automatic logic [2:0] grant_to_sel(input grant_t grant, input logic [1:0] cause);
        case (grant)
            G_DATA:  return SEL_ALUOUT;
            G_EXC:   return cause_to_sel(cause);
            default: return SEL_PC;
        endcase
    endfunction

endpackage

// File: rtl/mem_lat_cnt.sv
// Loadable down-counter timing the WAIT phase of a memory access; the zero flag
// tells the sequencer the memory data is valid.
module mem_lat_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-port sequencer for the multicycle CPU: arbitrates exc > data > fetch,
// drives the address-mux select and times each access. Optional MISALIGN_CHK_EN.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fetch_req,
    input  logic       data_req,
    input  logic       data_wr,
    input  logic [1:0] data_addr_lo,
    input  logic       exc_req,
    input  logic [1:0] exc_cause,
    output logic [2:0] mem_sel,
    output logic       mem_wr,
    output logic       mem_rd_latch,
    output logic       fetch_ack,
    output logic       data_ack,
    output logic       exc_ack,
    output logic       busy,
    output logic       err
);

    // WAIT is entered with MEM_LAT-1 so that it lasts exactly MEM_LAT cycles.
    localparam logic [CNT_W-1:0] LOAD_VAL = (MEM_LAT == 0) ? '0 : CNT_W'(MEM_LAT - 1);

    state_t     state, state_nxt;
    grant_t     grant_q, grant_nxt;
    logic       wr_q;
    logic [1:0] cause_q;
    logic       misalign_q, misalign_nxt;
    logic       any_req;
    logic       cnt_load, cnt_dec, cnt_zero;
    logic       is_store;

    assign any_req  = fetch_req | data_req | exc_req;
    assign is_store = (grant_q == G_DATA) && wr_q;

    always_comb begin
        grant_nxt = G_FETCH;
        if (exc_req) begin
            grant_nxt = G_EXC;
        end else if (data_req) begin
            grant_nxt = G_DATA;
        end
    end

`ifdef MISALIGN_CHK_EN
    assign misalign_nxt = (grant_nxt == G_DATA) && (data_addr_lo != 2'b00);
`else
    logic unused_addr_lo;
    assign unused_addr_lo = ^data_addr_lo;
    assign misalign_nxt   = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant_q    <= G_FETCH;
            wr_q       <= 1'b0;
            cause_q    <= 2'b00;
            misalign_q <= 1'b0;
        end else begin
            state <= state_nxt;
            // Grant and its attributes are frozen for the whole access.
            if ((state == IDLE) && any_req) begin
                grant_q    <= grant_nxt;
                wr_q       <= data_wr;
                cause_q    <= exc_cause;
                misalign_q <= misalign_nxt;
            end
        end
    end

    mem_lat_cnt #(
        .CNT_W(CNT_W)
    ) u_lat_cnt (
        .clk     (clk),
        .rst     (reset),
        .load    (cnt_load),
        .dec     (cnt_dec),
        .load_val(LOAD_VAL),
        .zero    (cnt_zero)
    );

    always_comb begin
        state_nxt    = state;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        mem_sel      = SEL_PC;
        mem_wr       = 1'b0;
        mem_rd_latch = 1'b0;
        fetch_ack    = 1'b0;
        data_ack     = 1'b0;
        exc_ack      = 1'b0;
        busy         = 1'b1;
        err          = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (any_req) begin
                    state_nxt = misalign_nxt ? DONE : ADDR;
                end
            end
            ADDR: begin
                mem_sel   = grant_to_sel(grant_q, cause_q);
                mem_wr    = is_store;
                cnt_load  = 1'b1;
                state_nxt = (MEM_LAT == 0) ? DONE : WAIT;
            end
            WAIT: begin
                mem_sel = grant_to_sel(grant_q, cause_q);
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                mem_sel      = grant_to_sel(grant_q, cause_q);
                mem_rd_latch = !is_store && !misalign_q;
                fetch_ack    = (grant_q == G_FETCH);
                data_ack     = (grant_q == G_DATA);
                exc_ack      = (grant_q == G_EXC);
                err          = misalign_q;
                state_nxt    = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
